// File: rtl/data_mem_arbiter.sv
// Data memory sequencer: arbitrates MEM-stage and loader accesses, stretches each
// access by WAIT_CYCLES, freezes the pipeline during CPU accesses and registers read data.
module data_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_freeze,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic [31:0] ldr_rdata,
  output logic        ldr_done,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_result,
  output logic [1:0]  dbg_state
);

  // Handshakes: a CPU request (cpu_rd|cpu_wr) is held by the pipeline and completes
  // in the one cycle where it is pending and cpu_freeze is low; a loader request
  // (ldr_req) completes on the ldr_done pulse. Requester fields are only sampled at grant.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0] state;
  logic       owner;
  logic       last;
  logic       is_wr;
  logic [3:0] cnt;

  logic cpu_pend;
  logic grant;
  logic grant_ldr;
  logic cnt_zero;

  assign cpu_pend = cpu_rd | cpu_wr;
  assign grant    = cpu_pend | ldr_req;
  // On a tie the requester that did not win last time goes first.
  assign grant_ldr = ldr_req & (~cpu_pend | (last == OWN_CPU));
  assign cnt_zero  = (cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= OWN_CPU;
      last      <= OWN_LDR;
      is_wr     <= 1'b0;
      cnt       <= 4'd0;
      mem_addr  <= 32'h0;
      mem_data  <= 32'h0;
      cpu_rdata <= 32'h0;
      ldr_rdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            state <= S_ACC;
            cnt   <= WAIT_INIT;
            owner <= grant_ldr;
            if (grant_ldr) begin
              mem_addr <= ldr_addr;
              mem_data <= ldr_wdata;
              is_wr    <= ldr_we;
            end else begin
              mem_addr <= cpu_addr;
              mem_data <= cpu_wdata;
              is_wr    <= cpu_wr;
            end
          end
        end
        S_ACC: begin
          if (!cnt_zero) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!is_wr) begin
              if (owner == OWN_CPU) cpu_rdata <= mem_result;
              else                  ldr_rdata <= mem_result;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          last  <= owner;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_read   = (state == S_ACC) & ~is_wr;
  assign mem_write  = (state == S_ACC) & is_wr & cnt_zero;
  assign ldr_done   = (state == S_DONE) & (owner == OWN_LDR);
  assign cpu_freeze = cpu_pend & ~((state == S_DONE) & (owner == OWN_CPU));
  assign dbg_state  = state;

endmodule
